// File: rtl/stream_xbar_pkg.sv
// stream_xbar_pkg: shared beat type and width helper for the packet crossbar
package stream_xbar_pkg;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int BEAT_DATA_W = 8;
  localparam int BEAT_DEST_W = clog2_min1(4);
  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic [BEAT_DEST_W-1:0] dest;
    logic                   last;
  } beat_t;
endpackage

// File: rtl/xbar_pkt_arbiter.sv
// xbar_pkt_arbiter: round-robin arbiter that holds its grant for a whole packet
module xbar_pkt_arbiter
  import stream_xbar_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = clog2_min1(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  input  logic           adv,
  output logic           fire,
  output logic [IDW-1:0] sel
);
  logic           locked;
  logic [IDW-1:0] owner, ptr, rr, idx;
  always_comb begin
    rr = ptr;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (req[idx]) rr = idx;
    end
    sel = locked ? owner : rr;
    fire = adv && (locked ? req[owner] : |req);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      locked <= 1'b0;
      owner <= '0;
      ptr <= '0;
    end else if (fire) begin
      if (last[sel]) begin
        locked <= 1'b0;
        ptr <= IDW'((int'(sel) + 1) % N);
      end else begin
        locked <= 1'b1;
        owner <= sel;
      end
    end
endmodule

// File: rtl/stream_xbar_pkt.sv
// stream_xbar_pkt: packet-locked stream crossbar with per-input FIFOs and registered outputs
module stream_xbar_pkt
  import stream_xbar_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 4,
  parameter int M_DATA_COUNT = 4,
  parameter int FIFO_DEPTH   = 4,
  localparam int T_ID___WIDTH = clog2_min1(S_DATA_COUNT),
  localparam int T_DEST_WIDTH = clog2_min1(M_DATA_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                   s_last_i,
  input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
  output logic [S_DATA_COUNT-1:0]                   s_ready_o,
  output logic [S_DATA_COUNT-1:0]                   s_drop_o,
  output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
  output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] m_id_o,
  output logic [M_DATA_COUNT-1:0]                   m_last_o,
  output logic [M_DATA_COUNT-1:0]                   m_valid_o,
  input  logic [M_DATA_COUNT-1:0]                   m_ready_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic [T_DEST_WIDTH-1:0] dest;
    logic                    last;
  } fifo_beat_t;
  fifo_beat_t                                    head [S_DATA_COUNT];
  logic [S_DATA_COUNT-1:0]                       avail, drop, pop, push, head_last;
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0]     req;
  logic [M_DATA_COUNT-1:0]                       fire, adv;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]     sel;
  for (genvar i = 0; i < S_DATA_COUNT; i++) begin : g_in
    fifo_beat_t     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  cnt, vcnt;
    logic           push_q;
    assign s_ready_o[i] = cnt != CW'(FIFO_DEPTH);
    assign push[i] = s_valid_i[i] && s_ready_o[i];
    assign avail[i] = vcnt != '0;
    assign head[i] = mem[rd_ptr];
    assign head_last[i] = head[i].last;
    assign drop[i] = avail[i] && (32'(head[i].dest) >= M_DATA_COUNT);
    assign s_drop_o[i] = drop[i];
    always_ff @(posedge clk)
      if (push[i]) mem[wr_ptr] <= {s_data_i[i], s_dest_i[i], s_last_i[i]};
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt <= '0;
        vcnt <= '0;
        push_q <= 1'b0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push[i]);
        rd_ptr <= rd_ptr + AW'(pop[i]);
        cnt <= cnt + CW'(push[i]) - CW'(pop[i]);
        push_q <= push[i];
        vcnt <= vcnt + CW'(push_q) - CW'(pop[i]);
      end
  end
  always_comb begin
    req = '0;
    for (int o = 0; o < M_DATA_COUNT; o++)
      for (int i = 0; i < S_DATA_COUNT; i++)
        req[o][i] = avail[i] && !drop[i] && (32'(head[i].dest) == o);
  end
  always_comb begin
    pop = drop;
    for (int o = 0; o < M_DATA_COUNT; o++)
      if (fire[o]) pop[sel[o]] = 1'b1;
  end
  assign adv = ~m_valid_o | m_ready_i;
  for (genvar o = 0; o < M_DATA_COUNT; o++) begin : g_out
    xbar_pkt_arbiter #(.N(S_DATA_COUNT), .IDW(T_ID___WIDTH)) u_arb (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req[o]),
      .last (head_last),
      .adv  (adv[o]),
      .fire (fire[o]),
      .sel  (sel[o])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid_o <= '0;
      m_data_o <= '0;
      m_id_o <= '0;
      m_last_o <= '0;
    end else begin
      for (int o = 0; o < M_DATA_COUNT; o++)
        if (adv[o]) begin
          m_valid_o[o] <= fire[o];
          if (fire[o]) begin
            m_data_o[o] <= head[sel[o]].data;
            m_id_o[o] <= sel[o];
            m_last_o[o] <= head[sel[o]].last;
          end
        end
    end
endmodule

// File: tb/tb_stream_xbar_pkt.sv
// tb_stream_xbar_pkt: directed self-checking bench for the packet crossbar
module tb_stream_xbar_pkt;
  logic            clk, rst_n;
  logic [3:0][7:0] s_data, m_data, s3_data;
  logic [3:0][1:0] s_dest, m_id, s3_dest;
  logic [3:0]      s_last, s_valid, s_ready, s_drop, m_last, m_valid, m_ready;
  logic [3:0]      s3_last, s3_valid, s3_ready, s3_drop;
  logic [2:0][7:0] m3_data;
  logic [2:0][1:0] m3_id;
  logic [2:0]      m3_last, m3_valid, m3_ready;
  logic [15:0]     obs [4][$];
  int              n_chk, n_pass, sent;
  logic            acc, any_v;

  stream_xbar_pkt u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data), .s_dest_i(s_dest), .s_last_i(s_last), .s_valid_i(s_valid),
    .s_ready_o(s_ready), .s_drop_o(s_drop),
    .m_data_o(m_data), .m_id_o(m_id), .m_last_o(m_last), .m_valid_o(m_valid), .m_ready_i(m_ready)
  );

  stream_xbar_pkt #(.M_DATA_COUNT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s3_data), .s_dest_i(s3_dest), .s_last_i(s3_last), .s_valid_i(s3_valid),
    .s_ready_o(s3_ready), .s_drop_o(s3_drop),
    .m_data_o(m3_data), .m_id_o(m3_id), .m_last_o(m3_last), .m_valid_o(m3_valid), .m_ready_i(m3_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    for (int o = 0; o < 4; o++)
      if (m_valid[o] && m_ready[o]) obs[o].push_back({4'(m_id[o]), 3'b0, m_last[o], m_data[o]});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    for (int o = 0; o < 4; o++) obs[o].delete();
  endtask

  function automatic logic [31:0] obs_at(input int o, input int n);
    return (n < obs[o].size()) ? 32'(obs[o][n]) : 32'hffff_ffff;
  endfunction

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    s_data = '0; s_dest = '0; s_last = '0; s_valid = '0; m_ready = '1;
    s3_data = '0; s3_dest = '0; s3_last = '0; s3_valid = '0; m3_ready = '1;
    repeat (2) step();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_id", m_id, 0);
    chk("rst_last", m_last, 0);
    chk("rst_drop", s_drop, 0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", s_ready, 4'hf);

    clear_obs();
    s_valid[0] = 1'b1; s_data[0] = 8'h5a; s_dest[0] = 2'd2; s_last[0] = 1'b1;
    step();
    s_valid = '0; s_last = '0;
    chk("single_e1", m_valid, 0);
    step();
    chk("single_e2", m_valid, 0);
    step();
    chk("single_e3_valid", m_valid, 4'b0100);
    chk("single_e3_data", m_data[2], 8'h5a);
    chk("single_e3_id", m_id[2], 0);
    chk("single_e3_last", m_last[2], 1);
    step();
    chk("single_e4", m_valid, 0);

    clear_obs();
    for (int k = 0; k < 3; k++) begin
      s_valid = 4'b0011;
      s_dest[0] = 2'd1; s_dest[1] = 2'd1;
      s_data[0] = 8'(16 + k); s_data[1] = 8'(32 + k);
      s_last = {2'b00, k == 2, k == 2};
      step();
    end
    s_valid = '0; s_last = '0;
    repeat (12) step();
    chk("cont_count", obs[1].size(), 6);
    chk("cont_b0", obs_at(1, 0), 32'h0010);
    chk("cont_b1", obs_at(1, 1), 32'h0011);
    chk("cont_b2", obs_at(1, 2), 32'h0112);
    chk("cont_b3", obs_at(1, 3), 32'h1020);
    chk("cont_b4", obs_at(1, 4), 32'h1021);
    chk("cont_b5", obs_at(1, 5), 32'h1122);

    clear_obs();
    m_ready = 4'b1110;
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      s_valid[2] = sent < 8; s_data[2] = 8'(160 + sent); s_dest[2] = 2'd0; s_last[2] = sent == 7;
      acc = s_valid[2] && s_ready[2];
      step();
      if (acc) sent++;
    end
    chk("bp_accepted", sent, 5);
    chk("bp_ready_low", s_ready[2], 0);
    chk("bp_hold", {m_valid[0], m_data[0]}, {1'b1, 8'ha0});
    m_ready = 4'hf;
    for (int c = 0; c < 30; c++) begin
      s_valid[2] = sent < 8; s_data[2] = 8'(160 + sent); s_last[2] = sent == 7;
      acc = s_valid[2] && s_ready[2];
      step();
      if (acc) sent++;
    end
    s_valid = '0; s_last = '0;
    chk("bp_sent", sent, 8);
    chk("bp_count", obs[0].size(), 8);
    for (int n = 0; n < 8; n++)
      chk($sformatf("bp_b%0d", n), obs_at(0, n), {16'h0, 4'd2, 3'b0, n == 7, 8'(160 + n)});

    s3_valid[1] = 1'b1; s3_data[1] = 8'h77; s3_dest[1] = 2'd3; s3_last[1] = 1'b1;
    step();
    s3_valid = '0; s3_last = '0;
    chk("drop_e1", s3_drop, 0);
    step();
    chk("drop_pulse", s3_drop, 4'b0010);
    any_v = |m3_valid;
    step();
    chk("drop_end", s3_drop, 0);
    for (int c = 0; c < 4; c++) begin
      any_v = any_v | (|m3_valid);
      step();
    end
    chk("drop_no_valid", any_v, 0);
    chk("drop_ready", s3_ready, 4'hf);

    clear_obs();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        s_valid[i] = 1'b1; s_dest[i] = 2'd3; s_data[i] = 8'(i * 16 + k); s_last[i] = 1'b1;
      end
      step();
    end
    s_valid = '0; s_last = '0;
    repeat (20) step();
    chk("fair_count", obs[3].size(), 12);
    for (int n = 0; n < 12; n++)
      chk($sformatf("fair_b%0d", n), obs_at(3, n), {16'h0, 4'(n % 4), 3'b0, 1'b1, 8'((n % 4) * 16 + n / 4)});

    s_valid[0] = 1'b1; s_dest[0] = 2'd1; s_data[0] = 8'hb0; s_last[0] = 1'b0;
    step();
    s_data[0] = 8'hb1;
    step();
    s_valid = '0;
    step();
    chk("rstm_pre", {m_valid[1], m_data[1]}, {1'b1, 8'hb0});
    rst_n = 1'b0;
    #1;
    chk("rstm_valid", m_valid, 0);
    chk("rstm_data", m_data, 0);
    chk("rstm_id", m_id, 0);
    chk("rstm_last", m_last, 0);
    chk("rstm_drop", s_drop, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rstm_ready", s_ready, 4'hf);
    clear_obs();
    for (int k = 0; k < 4; k++) begin
      s_valid[0] = 1'b1; s_dest[0] = 2'd1; s_data[0] = 8'(208 + k); s_last[0] = k == 3;
      step();
    end
    s_valid = '0; s_last = '0;
    repeat (10) step();
    chk("rstm_count", obs[1].size(), 4);
    for (int n = 0; n < 4; n++)
      chk($sformatf("rstm_b%0d", n), obs_at(1, n), {16'h0, 4'd0, 3'b0, n == 3, 8'(208 + n)});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
